// File: rtl/load_unit_pkg.sv
// Shared types and legality helpers for the RV32I load unit.
package LoadTypePackage;

    // RV32I load encodings (instr[14:12])
    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } LoadFunct3;

    // Load unit control states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        RESP = 2'b11
    } LoadState;

    // True for the five funct3 encodings that name a real load
    function automatic logic is_legal_funct3(input logic [2:0] funct3);
        logic legal;
        case (funct3)
            LB, LH, LW, LBU, LHU: legal = 1'b1;
            default:              legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Halfwords need an even address, words need a 4-byte aligned address
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        logic mis;
        case (funct3)
            LH, LHU: mis = off[0];
            LW:      mis = (off != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_unit_if.sv
// Request, memory and response signals of the load unit bundled together.
// The slave modport is the load unit's view; master is its environment.
interface load_unit_if;

    logic        ld_valid;
    logic        ld_ready;
    logic [2:0]  ld_funct3;
    logic [31:0] ld_addr;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_misaligned;
    logic        rsp_fault;

    modport slave (
        input  ld_valid, ld_funct3, ld_addr,
        output ld_ready,
        output mem_req, mem_addr,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output rsp_valid, rsp_data, rsp_misaligned, rsp_fault,
        input  rsp_ready
    );

    modport master (
        output ld_valid, ld_funct3, ld_addr,
        input  ld_ready,
        input  mem_req, mem_addr,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  rsp_valid, rsp_data, rsp_misaligned, rsp_fault,
        output rsp_ready
    );

endinterface

// File: rtl/load_unit_align.sv
// Selects the addressed byte/halfword of a read word and extends it to 32 bits.
module load_align
    import LoadTypePackage::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    output logic [31:0] result
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane select for byte and halfword accesses
    always_comb begin
        byte_s = 8'h00;
        case (off)
            2'b00:   byte_s = mem_rdata[7:0];
            2'b01:   byte_s = mem_rdata[15:8];
            2'b10:   byte_s = mem_rdata[23:16];
            2'b11:   byte_s = mem_rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        half_s = off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    end

    // Sign or zero extension according to the load type
    always_comb begin
        result = 32'h0000_0000;
        case (funct3)
            LB:      result = {{24{byte_s[7]}}, byte_s};
            LBU:     result = {24'h00_0000, byte_s};
            LH:      result = {{16{half_s[15]}}, half_s};
            LHU:     result = {16'h0000, half_s};
            LW:      result = mem_rdata;
            default: result = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// RV32I load unit: one word-aligned memory read per load, result aligned and
// extended, returned over a valid/ready handshake. Illegal or misaligned loads
// are answered immediately; a memory that never answers yields a fault.
module load_unit
    import LoadTypePackage::*;
#(
    parameter int TIMEOUT_CYCLES = 16
)(
    input  logic        clk,
    input  logic        rst,
    load_unit_if.slave  bus
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    LoadState     state_r;
    logic [2:0]   funct3_r;
    logic [1:0]   off_r;
    logic [CW-1:0] cnt_r;

    logic         ld_ready_r;
    logic         mem_req_r;
    logic [31:0]  mem_addr_r;
    logic         rsp_valid_r;
    logic [31:0]  rsp_data_r;
    logic         rsp_mis_r;
    logic         rsp_fault_r;

    logic         req_bad_s;
    logic [31:0]  align_data_s;

    // Incoming request needs no memory access when it is illegal or misaligned
    always_comb begin
        req_bad_s = !is_legal_funct3(bus.ld_funct3) ||
                    is_misaligned(bus.ld_funct3, bus.ld_addr[1:0]);
    end

    load_align u_align (
        .mem_rdata (bus.mem_rdata),
        .funct3    (funct3_r),
        .off       (off_r),
        .result    (align_data_s)
    );

    // Control FSM; every output is a register updated on state transitions
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            funct3_r    <= 3'b000;
            off_r       <= 2'b00;
            cnt_r       <= '0;
            ld_ready_r  <= 1'b1;
            mem_req_r   <= 1'b0;
            mem_addr_r  <= 32'h0000_0000;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 32'h0000_0000;
            rsp_mis_r   <= 1'b0;
            rsp_fault_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.ld_valid) begin
                        funct3_r   <= bus.ld_funct3;
                        off_r      <= bus.ld_addr[1:0];
                        mem_addr_r <= {bus.ld_addr[31:2], 2'b00};
                        ld_ready_r <= 1'b0;
                        if (req_bad_s) begin
                            state_r     <= RESP;
                            rsp_valid_r <= 1'b1;
                            rsp_mis_r   <= 1'b1;
                            rsp_data_r  <= 32'h0000_0000;
                        end else begin
                            state_r   <= REQ;
                            mem_req_r <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    // rvalid is deliberately not looked at before the grant
                    if (bus.mem_gnt) begin
                        state_r   <= WAIT;
                        mem_req_r <= 1'b0;
                        cnt_r     <= '0;
                    end
                end
                WAIT: begin
                    cnt_r <= cnt_r + CW'(1);
                    // Data arriving on the last allowed cycle still beats the timeout
                    if (bus.mem_rvalid) begin
                        state_r     <= RESP;
                        rsp_valid_r <= 1'b1;
                        rsp_data_r  <= align_data_s;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r     <= RESP;
                        rsp_valid_r <= 1'b1;
                        rsp_fault_r <= 1'b1;
                        rsp_data_r  <= 32'h0000_0000;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state_r     <= IDLE;
                        rsp_valid_r <= 1'b0;
                        rsp_mis_r   <= 1'b0;
                        rsp_fault_r <= 1'b0;
                        ld_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    ld_ready_r  <= 1'b1;
                    mem_req_r   <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    rsp_mis_r   <= 1'b0;
                    rsp_fault_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ld_ready       = ld_ready_r;
    assign bus.mem_req        = mem_req_r;
    assign bus.mem_addr       = mem_addr_r;
    assign bus.rsp_valid      = rsp_valid_r;
    assign bus.rsp_data       = rsp_data_r;
    assign bus.rsp_misaligned = rsp_mis_r;
    assign bus.rsp_fault      = rsp_fault_r;

endmodule
